cen_frac_gen: RTL and testbench

Multi-channel fractional clock-enable generator for arcade cores running on `clk_sys`. Each channel emits single-cycle `cen` pulses at an average rate of `num/den` of `clk_sys`, programmable at runtime. It replaces the fixed integer `clk_en` dividers and the ad-hoc toggle divider used for the sound clock. It also adds per-channel pause and a global phase resync.

---
 rtl/cen_frac_gen.sv | 93 +++++++++
 tb/tb_cen_frac_gen.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cen_frac_gen.sv
// Multi-channel fractional clock-enable generator: each channel pulses cen at num/den of clk_sys.
// Optional divided-clock toggle outputs are enabled with `define CEN_FRAC_GEN_TOGGLE_EN.
module cen_frac_gen #(
   parameter  int NUM_CH = 4,
   parameter  int ACC_W  = 16,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [ACC_W-1:0]  cfg_num,
   input  logic [ACC_W-1:0]  cfg_den,
   input  logic [NUM_CH-1:0] pause,
   input  logic              resync,
   output logic [NUM_CH-1:0] cen,
   output logic [NUM_CH-1:0] clk_div
);

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [ACC_W-1:0] r_num;
      logic [ACC_W-1:0] r_den;
      logic [ACC_W:0]   r_acc;
      logic             r_cen;
      logic [ACC_W:0]   w_sum;
      logic [ACC_W:0]   w_den_x;
      logic [ACC_W:0]   w_acc_nxt;
      logic             w_cen_nxt;
      logic             w_wr;

      // Channel indices at or beyond NUM_CH never match, so such writes are dropped.
      assign w_wr    = cfg_we && (32'(cfg_ch) == gi);
      assign w_den_x = {1'b0, r_den};
      assign w_sum   = r_acc + {1'b0, r_num};

      always_comb begin
         w_acc_nxt = r_acc;
         w_cen_nxt = 1'b0;
         if (w_wr || resync) begin
            w_acc_nxt = '0;
         end else if (pause[gi]) begin
            w_acc_nxt = r_acc;
         end else if (r_den == '0) begin
            w_acc_nxt = '0;
         end else if (r_num >= r_den) begin
            // Saturated ratio: fire every cycle and keep acc below den.
            w_cen_nxt = 1'b1;
         end else if (w_sum >= w_den_x) begin
            w_acc_nxt = w_sum - w_den_x;
            w_cen_nxt = 1'b1;
         end else begin
            w_acc_nxt = w_sum;
         end
      end

      always_ff @(posedge clk_sys or posedge reset) begin
         if (reset) begin
            r_num <= '0;
            r_den <= '0;
            r_acc <= '0;
            r_cen <= 1'b0;
         end else begin
            if (w_wr) begin
               r_num <= cfg_num;
               r_den <= cfg_den;
            end
            r_acc <= w_acc_nxt;
            r_cen <= w_cen_nxt;
         end
      end

      assign cen[gi] = r_cen;

`ifdef CEN_FRAC_GEN_TOGGLE_EN
      logic r_div;

      always_ff @(posedge clk_sys or posedge reset) begin
         if (reset) begin
            r_div <= 1'b0;
         end else if (w_wr || resync) begin
            r_div <= 1'b0;
         end else if (w_cen_nxt) begin
            r_div <= ~r_div;
         end
      end

      assign clk_div[gi] = r_div;
`else
      assign clk_div[gi] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_cen_frac_gen.sv
// Directed self-checking bench for cen_frac_gen (NUM_CH=4, ACC_W=16).
module tb_cen_frac_gen;
   localparam int NUM_CH = 4;
   localparam int ACC_W  = 16;

   logic              clk_sys = 1'b0;
   logic              reset;
   logic              cfg_we;
   logic [1:0]        cfg_ch;
   logic [ACC_W-1:0]  cfg_num;
   logic [ACC_W-1:0]  cfg_den;
   logic [NUM_CH-1:0] pause;
   logic              resync;
   logic [NUM_CH-1:0] cen;
   logic [NUM_CH-1:0] clk_div;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk_sys = ~clk_sys;

   cen_frac_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .cfg_we  (cfg_we),
      .cfg_ch  (cfg_ch),
      .cfg_num (cfg_num),
      .cfg_den (cfg_den),
      .pause   (pause),
      .resync  (resync),
      .cen     (cen),
      .clk_div (clk_div)
   );

   task automatic tick();
      @(posedge clk_sys);
      #1;
      cyc++;
   endtask

   task automatic wr(input int ch, input int n, input int d);
      cfg_ch  = 2'(ch);
      cfg_num = 16'(n);
      cfg_den = 16'(d);
      cfg_we  = 1'b1;
      tick();
      cfg_we  = 1'b0;
   endtask

   task automatic test_reset();
      int nz;
      tick();
      tick();
      total++;
      if (cen !== 4'b0000) begin bad++; $display("FAIL reset_cen: got %b want 0000", cen); end
      total++;
      if (clk_div !== 4'b0000) begin bad++; $display("FAIL reset_clk_div: got %b want 0000", clk_div); end
      reset = 1'b0;
      nz = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (cen !== 4'b0000) nz++;
      end
      total++;
      if (nz !== 0) begin bad++; $display("FAIL unwritten_silent: got %0d active cycles want 0", nz); end
   endtask

   task automatic test_integer_divide();
      int first, last, n, gapbad;
      first = -1; last = -1; n = 0; gapbad = 0;
      wr(0, 1, 18);
      for (int k = 1; k <= 180; k++) begin
         tick();
         if (cen[0]) begin
            if (first < 0) first = k;
            else if (k - last != 18) gapbad++;
            last = k;
            n++;
         end
      end
      total++;
      if (n !== 10) begin bad++; $display("FAIL int_count: got %0d want 10", n); end
      total++;
      if (first !== 18) begin bad++; $display("FAIL int_first: got %0d want 18", first); end
      total++;
      if (gapbad !== 0) begin bad++; $display("FAIL int_gaps: got %0d bad gaps want 0", gapbad); end
   endtask

   task automatic test_fractional();
      int first1, last1, n1, gap1bad, last0, n0, gap0bad;
      first1 = -1; last1 = -1; n1 = 0; gap1bad = 0;
      last0 = -1; n0 = 0; gap0bad = 0;
      wr(1, 3, 10);
      for (int k = 1; k <= 1000; k++) begin
         tick();
         if (cen[1]) begin
            if (first1 < 0) first1 = k;
            else if ((k - last1 != 3) && (k - last1 != 4)) gap1bad++;
            last1 = k;
            n1++;
         end
         if (cen[0]) begin
            if (last0 >= 0 && k - last0 != 18) gap0bad++;
            last0 = k;
            n0++;
         end
      end
      total++;
      if (n1 !== 300) begin bad++; $display("FAIL frac_count: got %0d want 300", n1); end
      total++;
      if (first1 !== 4) begin bad++; $display("FAIL frac_first: got %0d want 4", first1); end
      total++;
      if (gap1bad !== 0) begin bad++; $display("FAIL frac_gaps: got %0d bad gaps want 0", gap1bad); end
      total++;
      if (gap0bad !== 0 || n0 < 55 || n0 > 56) begin
         bad++; $display("FAIL ch0_parallel: got count %0d badgaps %0d want 55..56 and 0", n0, gap0bad);
      end
   endtask

   task automatic test_saturation();
      int n;
      wr(2, 5, 5);
      n = 0;
      for (int k = 0; k < 20; k++) begin tick(); if (cen[2]) n++; end
      total++;
      if (n !== 20) begin bad++; $display("FAIL sat_eq: got %0d want 20", n); end
      wr(2, 10, 5);
      total++;
      if (cen[2] !== 1'b0) begin bad++; $display("FAIL write_clears_cen: got %b want 0", cen[2]); end
      n = 0;
      for (int k = 0; k < 20; k++) begin tick(); if (cen[2]) n++; end
      total++;
      if (n !== 20) begin bad++; $display("FAIL sat_gt: got %0d want 20", n); end
      wr(2, 5, 0);
      n = 0;
      for (int k = 0; k < 20; k++) begin tick(); if (cen[2]) n++; end
      total++;
      if (n !== 0) begin bad++; $display("FAIL den_zero: got %0d pulses want 0", n); end
   endtask

   task automatic test_pause();
      int p, gap, during, gap2;
      bit found;
      wr(0, 1, 18);
      found = 0; p = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         tick();
         if (cen[0]) begin found = 1; p = cyc; end
      end
      total++;
      if (!found) begin bad++; $display("FAIL pause_prepulse: got none want pulse within 40"); end
      repeat (4) tick();
      pause[0] = 1'b1;
      during = 0;
      for (int k = 0; k < 7; k++) begin tick(); if (cen[0]) during++; end
      pause[0] = 1'b0;
      total++;
      if (during !== 0) begin bad++; $display("FAIL pause_quiet: got %0d pulses want 0", during); end
      gap = -1;
      for (int k = 0; k < 40 && gap < 0; k++) begin
         tick();
         if (cen[0]) gap = cyc - p;
      end
      total++;
      if (gap !== 25) begin bad++; $display("FAIL pause_gap: got %0d want 25", gap); end
      p = cyc;
      gap2 = -1;
      for (int k = 0; k < 40 && gap2 < 0; k++) begin
         tick();
         if (cen[0]) gap2 = cyc - p;
      end
      total++;
      if (gap2 !== 18) begin bad++; $display("FAIL pause_after_gap: got %0d want 18", gap2); end
   endtask

   task automatic test_resync_write();
      int diff, n0, first;
      wr(0, 2, 7);
      repeat (3) tick();
      wr(3, 2, 7);
      diff = 0;
      for (int k = 0; k < 14; k++) begin tick(); if (cen[0] !== cen[3]) diff++; end
      total++;
      if (diff == 0) begin bad++; $display("FAIL resync_offset_setup: got %0d differing cycles want >0", diff); end
      resync = 1'b1;
      cfg_ch = 2'd3; cfg_num = 16'd2; cfg_den = 16'd7; cfg_we = 1'b1;
      tick();
      resync = 1'b0; cfg_we = 1'b0;
      total++;
      if (cen !== 4'b0000) begin bad++; $display("FAIL resync_cen: got %b want 0000", cen); end
      diff = 0; n0 = 0; first = -1;
      for (int k = 1; k <= 70; k++) begin
         tick();
         if (cen[0] !== cen[3]) diff++;
         if (cen[0]) begin n0++; if (first < 0) first = k; end
      end
      total++;
      if (diff !== 0) begin bad++; $display("FAIL resync_align: got %0d differing cycles want 0", diff); end
      total++;
      if (n0 !== 20) begin bad++; $display("FAIL resync_count: got %0d want 20", n0); end
      total++;
      if (first !== 4) begin bad++; $display("FAIL resync_first: got %0d want 4", first); end
   endtask

   task automatic test_back_to_back();
      int base, f1, f2;
      cfg_ch = 2'd1; cfg_num = 16'd1; cfg_den = 16'd3; cfg_we = 1'b1;
      tick();
      base = cyc;
      cfg_ch = 2'd2; cfg_num = 16'd1; cfg_den = 16'd5;
      tick();
      cfg_we = 1'b0;
      f1 = -1; f2 = -1;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (cen[1] && f1 < 0) f1 = cyc - base;
         if (cen[2] && f2 < 0) f2 = cyc - base;
      end
      total++;
      if (f1 !== 3) begin bad++; $display("FAIL b2b_ch1_first: got %0d want 3", f1); end
      total++;
      if (f2 !== 6) begin bad++; $display("FAIL b2b_ch2_first: got %0d want 6", f2); end
   endtask

   task automatic test_async_reset();
      int nz, derr, cerr;
      logic exp_div;
      wr(2, 5, 5);
      tick();
      tick();
      total++;
      if (cen[2] !== 1'b1) begin bad++; $display("FAIL arst_pre: got %b want 1", cen[2]); end
      #2;
      reset = 1'b1;
      #1;
      total++;
      if (cen !== 4'b0000) begin bad++; $display("FAIL arst_cen: got %b want 0000", cen); end
      total++;
      if (clk_div !== 4'b0000) begin bad++; $display("FAIL arst_clk_div: got %b want 0000", clk_div); end
      #2;
      reset = 1'b0;
      nz = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (cen !== 4'b0000 || clk_div !== 4'b0000) nz++;
      end
      total++;
      if (nz !== 0) begin bad++; $display("FAIL arst_silent: got %0d active cycles want 0", nz); end
      wr(0, 1, 4);
      derr = 0; cerr = 0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (cen[0] !== ((k % 4) == 0)) cerr++;
`ifdef CEN_FRAC_GEN_TOGGLE_EN
         exp_div = ((k / 4) % 2) == 1;
`else
         exp_div = 1'b0;
`endif
         if (clk_div[0] !== exp_div) derr++;
      end
      total++;
      if (cerr !== 0) begin bad++; $display("FAIL quarter_cen: got %0d wrong cycles want 0", cerr); end
      total++;
      if (derr !== 0) begin bad++; $display("FAIL clk_div_wave: got %0d wrong cycles want 0", derr); end
   endtask

   initial begin
      reset   = 1'b1;
      cfg_we  = 1'b0;
      cfg_ch  = '0;
      cfg_num = '0;
      cfg_den = '0;
      pause   = '0;
      resync  = 1'b0;
      test_reset();
      test_integer_divide();
      test_fractional();
      test_saturation();
      test_pause();
      test_resync_write();
      test_back_to_back();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
